// File: rtl/prefix_adder_arbiter_if.sv
// Bundle between the prefix-adder arbiter, its two requesters, the shared
// combinational adder and the response consumer.
interface prefix_adder_arbiter_if #(
   parameter int WIDTH = 8
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic             req0_cin;
   logic             req0_last;

   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic             req1_cin;
   logic             req1_last;

   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_b;
   logic             add_cin;
   logic [WIDTH-1:0] add_sum;
   logic             add_cout;

   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_sum;
   logic             rsp_cout;
   logic             rsp_last;

   // arbiter side
   modport slave (
      input  req0_valid, req0_a, req0_b, req0_cin, req0_last,
      input  req1_valid, req1_a, req1_b, req1_cin, req1_last,
      input  add_sum, add_cout, rsp_ready,
      output req0_ready, req1_ready, add_a, add_b, add_cin,
      output rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_last
   );

   // requester / adder / consumer side
   modport master (
      output req0_valid, req0_a, req0_b, req0_cin, req0_last,
      output req1_valid, req1_a, req1_b, req1_cin, req1_last,
      output add_sum, add_cout, rsp_ready,
      input  req0_ready, req1_ready, add_a, add_b, add_cin,
      input  rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_last
   );
endinterface

// File: rtl/prefix_adder_arbiter.sv
// Shares one combinational prefix adder between two requesters. Each request
// is a multi-beat packet (LSB beat first); carry is chained between beats
// internally, ownership is locked for a whole packet, and packets are granted
// round-robin. Every beat's {sum,cout} lands in a one-entry response register.
module prefix_adder_arbiter #(
   parameter int WIDTH = 8
) (
   input logic                  clk,
   input logic                  rst_n,
   prefix_adder_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t           state;
   logic             prio;      // requester that wins the next tie in IDLE
   logic             carry_q;   // carry chained into the next beat of the packet
   logic             rsp_valid;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_sum;
   logic             rsp_cout;
   logic             rsp_last;

   logic             gnt_any;
   logic             gnt_id;
   logic             slot_free;
   logic             sel_valid;
   logic             sel_ready;
   logic             sel_last;
   logic             accept;

   // Grant: owner is locked mid-packet, otherwise single valid wins or prio breaks the tie
   always_comb begin
      gnt_any = 1'b0;
      gnt_id  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req0_valid && bus.req1_valid) begin
               gnt_any = 1'b1;
               gnt_id  = prio;
            end else if (bus.req0_valid) begin
               gnt_any = 1'b1;
               gnt_id  = 1'b0;
            end else if (bus.req1_valid) begin
               gnt_any = 1'b1;
               gnt_id  = 1'b1;
            end
         end
         OWN0: begin
            gnt_any = 1'b1;
            gnt_id  = 1'b0;
         end
         OWN1: begin
            gnt_any = 1'b1;
            gnt_id  = 1'b1;
         end
         default: begin
            gnt_any = 1'b0;
            gnt_id  = 1'b0;
         end
      endcase
   end

   assign slot_free      = ~rsp_valid | bus.rsp_ready;
   assign bus.req0_ready = rst_n & gnt_any & ~gnt_id & slot_free;
   assign bus.req1_ready = rst_n & gnt_any &  gnt_id & slot_free;

   assign sel_valid = gnt_id ? bus.req1_valid : bus.req0_valid;
   assign sel_ready = gnt_id ? bus.req1_ready : bus.req0_ready;
   assign sel_last  = gnt_id ? bus.req1_last  : bus.req0_last;
   assign accept    = sel_valid & sel_ready;

   // Adder operand mux: first beat of a packet takes the requester's cin, later beats the chained carry
   always_comb begin
      bus.add_a   = '0;
      bus.add_b   = '0;
      bus.add_cin = 1'b0;
      if (gnt_any) begin
         bus.add_a   = gnt_id ? bus.req1_a : bus.req0_a;
         bus.add_b   = gnt_id ? bus.req1_b : bus.req0_b;
         bus.add_cin = (state == IDLE) ? (gnt_id ? bus.req1_cin : bus.req0_cin) : carry_q;
      end
   end

   // Packet FSM, round-robin pointer, carry chain and response register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         prio      <= 1'b0;
         carry_q   <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_sum   <= '0;
         rsp_cout  <= 1'b0;
         rsp_last  <= 1'b0;
      end else if (accept) begin
         rsp_valid <= 1'b1;
         rsp_id    <= gnt_id;
         rsp_sum   <= bus.add_sum;
         rsp_cout  <= bus.add_cout;
         rsp_last  <= sel_last;
         if (sel_last) begin
            state   <= IDLE;
            prio    <= ~gnt_id;
            carry_q <= 1'b0;
         end else begin
            state   <= gnt_id ? OWN1 : OWN0;
            carry_q <= bus.add_cout;
         end
      end else if (bus.rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_id    = rsp_id;
   assign bus.rsp_sum   = rsp_sum;
   assign bus.rsp_cout  = rsp_cout;
   assign bus.rsp_last  = rsp_last;
endmodule

// File: tb/tb_prefix_adder_arbiter.sv
// Bench for prefix_adder_arbiter: directed scenarios followed by random
// two-requester packet traffic scored against a long-integer addition model.
module tb_prefix_adder_arbiter;
   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         last;
   } beat_t;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         last;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   beat_t bq0[$], bq1[$];
   exp_t  eq0[$], eq1[$];

   prefix_adder_arbiter_if #(.WIDTH(W)) bus ();

   prefix_adder_arbiter #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // shared combinational adder
   assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {8'd0, bus.add_cin};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set0(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic last);
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b;
      bus.req0_cin = cin; bus.req0_last = last;
   endtask

   task automatic set1(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic last);
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b;
      bus.req1_cin = cin; bus.req1_last = last;
   endtask

   task automatic chk_rsp(input string tag, input logic id, input logic [W-1:0] sum,
                          input logic cout, input logic last);
      chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'(1'b1));
      chk({tag, "_id"},    32'(bus.rsp_id),    32'(id));
      chk({tag, "_sum"},   32'(bus.rsp_sum),   32'(sum));
      chk({tag, "_cout"},  32'(bus.rsp_cout),  32'(cout));
      chk({tag, "_last"},  32'(bus.rsp_last),  32'(last));
   endtask

   // Packet model: the whole packet is one long integer add; each beat is a
   // byte slice of the total, and its cout is the carry out of the prefix.
   task automatic gen_pkt(input int r);
      int          n;
      logic [39:0] av, bv, tot, part, mask;
      logic        cin;
      beat_t       bt;
      exp_t        et;
      n   = $urandom_range(1, 4);
      av  = '0;
      bv  = '0;
      cin = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
         bt.a    = 8'($urandom);
         bt.b    = 8'($urandom);
         bt.cin  = (i == 0) ? cin : 1'($urandom_range(0, 1));
         bt.last = (i == n - 1);
         av[8*i +: 8] = bt.a;
         bv[8*i +: 8] = bt.b;
         if (r == 0) bq0.push_back(bt); else bq1.push_back(bt);
      end
      tot = av + bv + {39'd0, cin};
      for (int i = 0; i < n; i++) begin
         mask    = (40'd1 << (8 * (i + 1))) - 40'd1;
         part    = (av & mask) + (bv & mask) + {39'd0, cin};
         et.sum  = tot[8*i +: 8];
         et.cout = part[8*(i+1)];
         et.last = (i == n - 1);
         if (r == 0) eq0.push_back(et); else eq1.push_back(et);
      end
   endtask

   initial begin
      int   cyc;
      int   open_id;
      logic acc0, acc1;
      exp_t e;

      set0(0, 0, 0, 0, 0);
      set1(0, 0, 0, 0, 0);
      bus.rsp_ready = 1'b1;

      // reset state, ready held low in reset even with a valid request
      repeat (2) @(negedge clk);
      set0(1, 8'h7F, 8'h01, 0, 1);
      #1;
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_rsp_sum",   32'(bus.rsp_sum),   0);
      chk("rst_rsp_id",    32'(bus.rsp_id),    0);
      chk("rst_ready0",    32'(bus.req0_ready), 0);

      // 1: single beat 0x7F+0x01
      @(negedge clk); rst_n = 1'b1; #1;
      chk("t1_ready0", 32'(bus.req0_ready), 1);
      chk("t1_ready1", 32'(bus.req1_ready), 0);
      chk("t1_add_a",  32'(bus.add_a), 32'h7F);
      @(negedge clk); set0(0, 0, 0, 0, 0); #1;
      chk_rsp("t1", 0, 8'h80, 0, 1);

      // 2: req1 two-beat packet, second beat's own cin must be ignored
      @(negedge clk); set1(1, 8'hFF, 8'h01, 0, 0); #1;
      chk("t2_ready1", 32'(bus.req1_ready), 1);
      @(negedge clk); set1(1, 8'h00, 8'h00, 0, 1); #1;
      chk_rsp("t2a", 1, 8'h00, 1, 0);
      chk("t2_add_cin", 32'(bus.add_cin), 1);
      @(negedge clk); set1(0, 0, 0, 0, 0); #1;
      chk_rsp("t2b", 1, 8'h01, 0, 1);

      // 3: both requesters stream single beats -> grants alternate
      @(negedge clk); set0(1, 8'h01, 8'h01, 0, 1); set1(1, 8'h02, 8'h02, 0, 1);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         chk("t3_gnt0", 32'(bus.req0_ready), 32'(i % 2 == 0));
         chk("t3_gnt1", 32'(bus.req1_ready), 32'(i % 2 == 1));
      end

      // 4: req0 three-beat packet locks out req1 until its last beat
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); set0(1, 8'(i), 8'(i), 0, (i == 2)); set1(1, 8'h05, 8'h05, 0, 1); #1;
         chk("t4_ready0", 32'(bus.req0_ready), 1);
         chk("t4_ready1", 32'(bus.req1_ready), 0);
      end
      @(negedge clk); set0(0, 0, 0, 0, 0); #1;
      chk("t4_ready1_after", 32'(bus.req1_ready), 1);
      chk_rsp("t4_last0", 0, 8'h04, 0, 1);
      @(negedge clk); set1(0, 0, 0, 0, 0); #1;
      chk_rsp("t4_rsp1", 1, 8'h0A, 0, 1);

      // 5: backpressure for 4 cycles, then back-to-back drain
      @(negedge clk); #1;
      @(negedge clk); bus.rsp_ready = 1'b0; set0(1, 8'h10, 8'h20, 0, 1); #1;
      chk("t5_ready0_empty", 32'(bus.req0_ready), 1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); set0(1, 8'h11, 8'h20, 0, 1); #1;
         chk("t5_ready0_held", 32'(bus.req0_ready), 0);
         chk("t5_sum_held",    32'(bus.rsp_sum), 32'h30);
         chk("t5_valid_held",  32'(bus.rsp_valid), 1);
      end
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk); bus.rsp_ready = 1'b1; set0(1, 8'(8'h10 + k), 8'h20, 0, 1); #1;
         chk("t5_ready0_run", 32'(bus.req0_ready), 1);
         chk("t5_sum_run",    32'(bus.rsp_sum), 32'(8'h30 + k - 1));
      end
      @(negedge clk); set0(0, 0, 0, 0, 0); #1;
      chk("t5_sum_final", 32'(bus.rsp_sum), 32'h33);

      // 6: reset after first beat of a two-beat packet discards it
      @(negedge clk); set0(1, 8'hFF, 8'h01, 0, 0); #1;
      chk("t6_ready0", 32'(bus.req0_ready), 1);
      @(negedge clk); set0(0, 0, 0, 0, 0); rst_n = 1'b0; #1;
      chk("t6_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("t6_ready0_rst", 32'(bus.req0_ready), 0);
      @(negedge clk); rst_n = 1'b1; set1(1, 8'h01, 8'h01, 0, 1); #1;
      chk("t6_ready1_idle", 32'(bus.req1_ready), 1);
      chk("t6_add_cin",     32'(bus.add_cin), 0);
      @(negedge clk); set1(0, 0, 0, 0, 0); #1;
      chk_rsp("t6_rsp", 1, 8'h02, 0, 1);

      // random traffic scored against the packet model
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      for (int p = 0; p < 40; p++) begin
         gen_pkt(0);
         gen_pkt(1);
      end
      cyc = 0; open_id = -1; acc0 = 1'b0; acc1 = 1'b0;
      while ((eq0.size() != 0 || eq1.size() != 0) && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (acc0) void'(bq0.pop_front());
         if (acc1) void'(bq1.pop_front());
         if (bq0.size() != 0)
            set0(($urandom_range(0, 3) != 0), bq0[0].a, bq0[0].b, bq0[0].cin, bq0[0].last);
         else
            set0(0, 0, 0, 0, 0);
         if (bq1.size() != 0)
            set1(($urandom_range(0, 3) != 0), bq1[0].a, bq1[0].b, bq1[0].cin, bq1[0].last);
         else
            set1(0, 0, 0, 0, 0);
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         #1;
         acc0 = bus.req0_valid & bus.req0_ready;
         acc1 = bus.req1_valid & bus.req1_ready;
         chk("both_ready", 32'(bus.req0_ready & bus.req1_ready), 0);
         if (bus.rsp_valid && bus.rsp_ready) begin
            if (open_id >= 0) chk("interleave", 32'(bus.rsp_id), 32'(open_id));
            open_id = bus.rsp_last ? -1 : int'(bus.rsp_id);
            if ((bus.rsp_id ? eq1.size() : eq0.size()) == 0) begin
               chk("rnd_extra_rsp", 32'(bus.rsp_valid), 0);
            end else begin
               e = bus.rsp_id ? eq1.pop_front() : eq0.pop_front();
               chk("rnd_sum",  32'(bus.rsp_sum),  32'(e.sum));
               chk("rnd_cout", 32'(bus.rsp_cout), 32'(e.cout));
               chk("rnd_last", 32'(bus.rsp_last), 32'(e.last));
            end
         end
      end
      chk("rnd_drained", 32'(eq0.size() + eq1.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
